// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - NCO/CORDIC widths, start constant and arctangent table
package nco_pkg;

  localparam int PHASE_W     = 20;
  localparam int CORDIC_PH_W = 16;
  localparam int OUT_W       = 12;
  localparam int INT_W       = 16;
  localparam int Z_W         = 18;
  localparam int N_STAGES    = 14;
  localparam int LAT         = 17;

  typedef logic signed [INT_W-1:0] int_t;
  typedef logic signed [Z_W-1:0]   z_t;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

  // round(2047 * 4 / 1.64676): two guard bits, pre-divided by the CORDIC gain
  localparam int_t X_START = 16'sd4972;

  // atan(2^-i) scaled so that 2^17 represents pi/2
  function automatic z_t atan_lut(input int i);
    case (i)
      0:       return 18'sd65536;
      1:       return 18'sd38688;
      2:       return 18'sd20442;
      3:       return 18'sd10377;
      4:       return 18'sd5208;
      5:       return 18'sd2607;
      6:       return 18'sd1304;
      7:       return 18'sd652;
      8:       return 18'sd326;
      9:       return 18'sd163;
      10:      return 18'sd81;
      11:      return 18'sd41;
      12:      return 18'sd20;
      13:      return 18'sd10;
      default: return 18'sd0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// rtl/cordic_stage.sv - one registered rotation-mode CORDIC micro-rotation
module cordic_stage
  import nco_pkg::*;
#(
  parameter int I = 0
) (
  input  logic clk,
  input  logic rst,
  input  int_t x,
  input  int_t y,
  input  z_t   z,
  input  logic valid,
  output int_t x_next,
  output int_t y_next,
  output z_t   z_next,
  output logic valid_next
);

  localparam z_t ATAN = atan_lut(I);

  int_t x_sh;
  int_t y_sh;

  assign x_sh = x >>> I;
  assign y_sh = y >>> I;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_next     <= '0;
      y_next     <= '0;
      z_next     <= '0;
      valid_next <= 1'b0;
    end else begin
      valid_next <= valid;
      // rotate toward zero residual angle
      if (z[Z_W-1]) begin
        x_next <= x + y_sh;
        y_next <= y - x_sh;
        z_next <= z + ATAN;
      end else begin
        x_next <= x - y_sh;
        y_next <= y + x_sh;
        z_next <= z - ATAN;
      end
    end
  end

endmodule

// File: rtl/nco_cordic.sv
// rtl/nco_cordic.sv - phase accumulator + pipelined CORDIC sine/cosine NCO
module nco_cordic
  import nco_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               En,
  input  logic [PHASE_W-1:0] FCW,
  input  logic               selXY,
  input  logic               selSign,
  output logic               Vld,
  output logic [OUT_W-1:0]   Dout
);

  logic [PHASE_W-1:0]     acc;
  logic [CORDIC_PH_W-1:0] phase;
  logic                   phase_vld;

  int_t fold_x;
  int_t fold_y;
  z_t   fold_z;
  logic fold_vld;

  int_t xs [0:N_STAGES-1];
  int_t ys [0:N_STAGES-1];
  z_t   zs [0:N_STAGES-1];
  logic vs [0:N_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      phase     <= '0;
      phase_vld <= 1'b0;
    end else begin
      phase_vld <= En;
      phase     <= acc[PHASE_W-1 -: CORDIC_PH_W];
      if (En) acc <= acc + FCW;
    end
  end

  // quadrant pre-rotation; residual angle in [0, pi/2)
  always_ff @(posedge clk) begin
    if (rst) begin
      fold_x   <= '0;
      fold_y   <= '0;
      fold_z   <= '0;
      fold_vld <= 1'b0;
    end else begin
      fold_vld <= phase_vld;
      fold_z   <= {1'b0, phase[CORDIC_PH_W-3:0], 3'b000};
      case (quad_e'(phase[CORDIC_PH_W-1 -: 2]))
        Q0:      begin fold_x <= X_START;  fold_y <= '0;       end
        Q1:      begin fold_x <= '0;       fold_y <= X_START;  end
        Q2:      begin fold_x <= -X_START; fold_y <= '0;       end
        default: begin fold_x <= '0;       fold_y <= -X_START; end
      endcase
    end
  end

  for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
    int_t xi;
    int_t yi;
    z_t   zi;
    logic vi;
    if (i == 0) begin : g_src
      assign xi = fold_x;
      assign yi = fold_y;
      assign zi = fold_z;
      assign vi = fold_vld;
    end else begin : g_src
      assign xi = xs[i-1];
      assign yi = ys[i-1];
      assign zi = zs[i-1];
      assign vi = vs[i-1];
    end
    cordic_stage #(.I(i)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .x          (xi),
      .y          (yi),
      .z          (zi),
      .valid      (vi),
      .x_next     (xs[i]),
      .y_next     (ys[i]),
      .z_next     (zs[i]),
      .valid_next (vs[i])
    );
  end

  logic unused_residual;
  assign unused_residual = ^zs[N_STAGES-1];

  int_t                    s_sel;
  logic signed [INT_W:0]   s_rnd;
  logic signed [OUT_W-1:0] s_sat;

  always_comb begin
    s_sel = selXY ? xs[N_STAGES-1] : ys[N_STAGES-1];
    s_rnd = ($signed({s_sel[INT_W-1], s_sel}) + 17'sd2) >>> 2;
    if (s_rnd > 17'sd2047)       s_sat = 12'sd2047;
    else if (s_rnd < -17'sd2047) s_sat = -12'sd2047;
    else                         s_sat = s_rnd[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Vld  <= 1'b0;
      Dout <= '0;
    end else begin
      Vld <= vs[N_STAGES-1];
      if (vs[N_STAGES-1])
        Dout <= selSign ? s_sat : {~s_sat[OUT_W-1], s_sat[OUT_W-2:0]};
    end
  end

endmodule

// File: tb/tb_nco_cordic.sv
// tb/tb_nco_cordic.sv - self-checking bench for nco_cordic (X and Y instances)
module tb_nco_cordic;

  logic        clk = 1'b0;
  logic        rst;
  logic        En;
  logic [19:0] FCW;
  logic        selSign;
  logic        vld_x, vld_y;
  logic [11:0] dout_x, dout_y;

  always #5 clk = ~clk;

  nco_cordic dut_x (
    .clk(clk), .rst(rst), .En(En), .FCW(FCW), .selXY(1'b1),
    .selSign(selSign), .Vld(vld_x), .Dout(dout_x)
  );

  nco_cordic dut_y (
    .clk(clk), .rst(rst), .En(En), .FCW(FCW), .selXY(1'b0),
    .selSign(selSign), .Vld(vld_y), .Dout(dout_y)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    total++;
    if (act - exp > tol || exp - act > tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d) at %0t", name, act, exp, tol, $time);
    end
  endtask

  function automatic int conv(input logic [11:0] raw, input bit signed_mode);
    if (signed_mode) return int'($signed(raw));
    return int'(raw);
  endfunction

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  // model: a sample launched on an En edge appears 16 edges later (17 cycles)
  typedef struct {
    int          due;
    int unsigned p;
  } pend_t;

  pend_t       pend[$];
  int          cyc      = 0;
  int unsigned acc_m    = 0;
  int          k_next   = 0;
  int          epoch    = 0;
  bit          exp_vld  = 0;
  bit          exp_mode = 0;
  int          exp_tol  = 0;
  int          exp_x    = 0;
  int          exp_y    = 0;
  int          exp_k    = 0;

  always @(posedge clk) begin : model
    real         th;
    int          sx, sy;
    int unsigned p;
    cyc++;
    if (rst) begin
      pend.delete();
      acc_m    = 0;
      k_next   = 0;
      exp_vld  = 0;
      exp_mode = 0;
      exp_tol  = 0;
      exp_x    = 0;
      exp_y    = 0;
      epoch++;
    end else begin
      exp_vld = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p  = pend[0].p;
        void'(pend.pop_front());
        th = 6.283185307179586 * real'(p) / 1048576.0;
        sx = rnd(2047.0 * $cos(th));
        sy = rnd(2047.0 * $sin(th));
        exp_vld  = 1;
        exp_mode = selSign;
        exp_tol  = 2;
        exp_x    = selSign ? sx : sx + 2048;
        exp_y    = selSign ? sy : sy + 2048;
        exp_k    = k_next;
        k_next++;
      end
      if (En) begin
        pend.push_back('{cyc + 16, acc_m});
        acc_m = (acc_m + FCW) & 32'h000F_FFFF;
      end
    end
  end

  logic [11:0] obs_x [0:4095];
  logic [11:0] obs_y [0:4095];
  int          seen_epoch = -1;

  always @(negedge clk) begin : cmp
    if (seen_epoch != epoch) begin
      seen_epoch = epoch;
      for (int i = 0; i < 4096; i++) begin
        obs_x[i] = 12'h800;
        obs_y[i] = 12'h800;
      end
    end
    check_near("vld_x", int'(vld_x), int'(exp_vld), 0);
    check_near("vld_y", int'(vld_y), int'(exp_vld), 0);
    check_near(exp_vld ? "dout_x" : "hold_x", conv(dout_x, exp_mode), exp_x, exp_tol);
    check_near(exp_vld ? "dout_y" : "hold_y", conv(dout_y, exp_mode), exp_y, exp_tol);
    if (exp_vld && exp_k < 4096) begin
      obs_x[exp_k] = dout_x;
      obs_y[exp_k] = dout_y;
    end
  end

  task automatic lit(input string name, input logic [11:0] raw, input bit mode, input int exp);
    check_near(name, conv(raw, mode), exp, 2);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int          qx [4] = '{4095, 2048, 1, 2048};
  int          qy [4] = '{2048, 4095, 2048, 1};
  logic        en_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; En = 1'b0; FCW = 20'd0; selSign = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_near("reset_vld", int'(vld_x), 0, 0);
    check_near("reset_dout_x", int'(dout_x), 0, 0);
    check_near("reset_dout_y", int'(dout_y), 0, 0);

    // continuous run, FCW = 4096 -> period 256 samples
    FCW = 20'd4096; En = 1'b1;
    repeat (16) @(negedge clk);
    check_near("latency_early", int'(vld_x), 0, 0);
    @(negedge clk);
    check_near("latency_rise", int'(vld_x), 1, 0);
    repeat (4000 - 17) @(negedge clk);
    lit("x_s0",   obs_x[0],   1, 2047);
    lit("y_s0",   obs_y[0],   1, 0);
    lit("x_s64",  obs_x[64],  1, 0);
    lit("y_s64",  obs_y[64],  1, 2047);
    lit("x_s128", obs_x[128], 1, -2047);
    lit("y_s192", obs_y[192], 1, -2047);
    lit("x_s256", obs_x[256], 1, 2047);

    // reset mid-stream, En kept high
    pulse_reset();
    check_near("rst_mid_vld", int'(vld_x), 0, 0);
    check_near("rst_mid_dout_x", int'(dout_x), 0, 0);
    check_near("rst_mid_dout_y", int'(dout_y), 0, 0);
    repeat (20) @(negedge clk);
    lit("restart_x0", obs_x[0], 1, 2047);
    lit("restart_y0", obs_y[0], 1, 0);

    // quarter-turn steps in offset binary
    pulse_reset();
    selSign = 1'b0; FCW = 20'd262144;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      lit("quarter_x", obs_x[i], 0, qx[i % 4]);
      lit("quarter_y", obs_y[i], 0, qy[i % 4]);
    end

    // gapped enable
    pulse_reset();
    selSign = 1'b1; FCW = 20'd4096;
    for (int j = 0; j < 5; j++) begin
      En = en_pat[j];
      @(negedge clk);
    end
    En = 1'b0;
    repeat (12) @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      check_near("gap_vld", int'(vld_x), int'(en_pat[j]), 0);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    lit("gap_x0", obs_x[0], 1, 2047);
    lit("gap_x1", obs_x[1], 1, 2046);
    lit("gap_x2", obs_x[2], 1, 2045);
    check_near("gap_hold_x", conv(dout_x, 1'b1), 2045, 2);

    // FCW = 0 holds phase, then 20'hFFFFF walks backwards through the wrap
    pulse_reset();
    FCW = 20'd0; En = 1'b1;
    repeat (30) @(negedge clk);
    FCW = 20'hFFFFF;
    repeat (1100) @(negedge clk);
    lit("fcw0_x5",   obs_x[5],    1, 2047);
    lit("fcw0_y29",  obs_y[29],   1, 0);
    lit("wrap_y1054", obs_y[1054], 1, -13);
    lit("wrap_x1054", obs_x[1054], 1, 2047);
    En = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
